// File: rtl/dac_interface_ad5686.sv
// Purpose : serial write master for an AD5686-class quad 16-bit DAC (24-bit frame, MSB first, plus LDAC pulse).
// Latency : command latched on the cs edge, acted on the next edge; write frame keeps rdy low 101 cycles at defaults.
// Backpressure: rdy low while busy; commands arriving then are dropped, except soft reset which always wins.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   SCLK, SYNC, DIN, LDAC DAC serial interface, all registered (SCLK/SYNC/LDAC idle high)
//   cs, op, addr, data_in single-cycle host command: op[0] soft reset, op[1] write+update,
//                         op[2] write input register, op[3] LDAC pulse; addr[3:0] channel mask
//   rdy                   idle and able to accept a command
module dac_interface_ad5686 #(
    parameter int NBIT      = 24,
    parameter int SCLK_HALF = 2,
    parameter int T_SETUP   = 2,
    parameter int T_QUIET   = 3,
    parameter int T_LDAC    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        SCLK,
    output logic        SYNC,
    output logic        DIN,
    output logic        LDAC,
    input  logic        cs,
    input  logic [3:0]  op,
    input  logic [7:0]  addr,
    input  logic [15:0] data_in,
    output logic        rdy
);

    // Phase counter must reach the longest hold in any state without wrapping.
    localparam int M1   = (2 * SCLK_HALF > T_SETUP) ? 2 * SCLK_HALF : T_SETUP;
    localparam int M2   = (T_QUIET > T_LDAC) ? T_QUIET : T_LDAC;
    localparam int CMAX = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(NBIT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        SHIFT  = 3'd2,
        QUIET  = 3'd3,
        LPULSE = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [BW-1:0] bit_cnt, bit_cnt_n;
    logic [23:0]   sr, sr_n;
    logic          sclk_q, sclk_n;
    logic          sync_q, sync_n;
    logic          din_q, din_n;
    logic          ldac_q, ldac_n;
    logic          rdy_q, rdy_n;

    logic          cmd_vld;
    logic [3:0]    cmd_op;
    logic [3:0]    cmd_addr;
    logic [15:0]   cmd_data;
    logic          accept;
    logic [3:0]    cmd_code;
    logic [23:0]   frame;

    // A command is only taken when idle with nothing pending; soft reset is always taken.
    assign accept   = cs && (((state == IDLE) && !cmd_vld) || op[0]);
    assign cmd_code = cmd_op[1] ? 4'b0011 : 4'b0001;
    assign frame    = {cmd_code, cmd_addr, cmd_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_vld  <= 1'b0;
            cmd_op   <= 4'd0;
            cmd_addr <= 4'd0;
            cmd_data <= 16'd0;
        end else begin
            cmd_vld <= accept;
            if (accept) begin
                cmd_op   <= op;
                cmd_addr <= addr[3:0];
                cmd_data <= data_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            sr      <= '0;
            sclk_q  <= 1'b1;
            sync_q  <= 1'b1;
            din_q   <= 1'b0;
            ldac_q  <= 1'b1;
            rdy_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            sr      <= sr_n;
            sclk_q  <= sclk_n;
            sync_q  <= sync_n;
            din_q   <= din_n;
            ldac_q  <= ldac_n;
            rdy_q   <= rdy_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        sr_n      = sr;
        sclk_n    = sclk_q;
        sync_n    = sync_q;
        din_n     = din_q;
        ldac_n    = ldac_q;
        rdy_n     = rdy_q;

        case (state)
            IDLE: begin
                rdy_n = 1'b1;
                if (cmd_vld && !cmd_op[0]) begin
                    if (cmd_op[1] || cmd_op[2]) begin
                        state_n   = SETUP;
                        cnt_n     = '0;
                        bit_cnt_n = '0;
                        sr_n      = frame;
                        sync_n    = 1'b0;
                        sclk_n    = 1'b1;
                        din_n     = frame[23];
                        rdy_n     = 1'b0;
                    end else if (cmd_op[3]) begin
                        state_n = LPULSE;
                        cnt_n   = '0;
                        ldac_n  = 1'b0;
                        rdy_n   = 1'b0;
                    end
                end
            end
            SETUP: begin
                if (cnt == CW'(T_SETUP - 1)) begin
                    state_n = SHIFT;
                    cnt_n   = '0;
                    sclk_n  = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SHIFT: begin
                // cnt runs 0..2*SCLK_HALF-1 per bit: low phase first, then high phase.
                if (cnt == CW'(SCLK_HALF - 1)) begin
                    sclk_n    = 1'b1;
                    sr_n      = {sr[22:0], 1'b0};
                    din_n     = sr[22];
                    bit_cnt_n = bit_cnt + 1'b1;
                    cnt_n     = cnt + 1'b1;
                end else if (cnt == CW'(2 * SCLK_HALF - 1)) begin
                    cnt_n = '0;
                    if (bit_cnt == BW'(NBIT)) begin
                        // Full high phase of the last bit done before SYNC rises.
                        state_n   = QUIET;
                        bit_cnt_n = '0;
                        sync_n    = 1'b1;
                        sclk_n    = 1'b1;
                        din_n     = 1'b0;
                    end else begin
                        sclk_n = 1'b0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            QUIET: begin
                if (cnt == CW'(T_QUIET - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    rdy_n   = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            LPULSE: begin
                if (cnt == CW'(T_LDAC - 1)) begin
                    state_n = QUIET;
                    cnt_n   = '0;
                    ldac_n  = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // Soft reset overrides whatever the FSM was doing, but leaves rdy high.
        if (cmd_vld && cmd_op[0]) begin
            state_n   = IDLE;
            cnt_n     = '0;
            bit_cnt_n = '0;
            sr_n      = '0;
            sclk_n    = 1'b1;
            sync_n    = 1'b1;
            din_n     = 1'b0;
            ldac_n    = 1'b1;
            rdy_n     = 1'b1;
        end
    end

    assign SCLK = sclk_q;
    assign SYNC = sync_q;
    assign DIN  = din_q;
    assign LDAC = ldac_q;
    assign rdy  = rdy_q;

endmodule

// File: tb/tb_dac_interface_ad5686.sv
// Purpose : directed bench for dac_interface_ad5686 (frames, LDAC pulse, busy drop, soft abort, async reset).
// Latency : inputs driven on the falling clk edge, outputs sampled on the falling edge.
// Backpressure: frame capture stops when rdy returns high, bounded by a cycle budget.
module tb_dac_interface_ad5686;

    logic        clk;
    logic        rst_n;
    logic        SCLK, SYNC, DIN, LDAC, rdy;
    logic        cs;
    logic [3:0]  op;
    logic [7:0]  addr;
    logic [15:0] data_in;

    int n_checks;
    int n_fail;

    logic [23:0] word;
    int nfalls, nedges, sync_low, rdy_low, ldac_low, last_iter;
    bit timed_out;
    int extra_sync;

    dac_interface_ad5686 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SCLK    (SCLK),
        .SYNC    (SYNC),
        .DIN     (DIN),
        .LDAC    (LDAC),
        .cs      (cs),
        .op      (op),
        .addr    (addr),
        .data_in (data_in),
        .rdy     (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; the command is latched on the following rising edge.
    task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [15:0] d);
        cs      = 1'b1;
        op      = o;
        addr    = a;
        data_in = d;
        @(negedge clk);
        cs = 1'b0;
    endtask

    // Samples one falling clk edge per iteration until rdy returns high after going low.
    task automatic capture(input int budget, input int inj_at, input logic [3:0] inj_op,
                           input logic [15:0] inj_data,
                           output logic [23:0] w, output int falls, output int edges,
                           output int s_low, output int r_low, output int l_low,
                           output int iter, output bit tmo);
        logic prev;
        bit   seen0;
        w = '0; falls = 0; edges = 0; s_low = 0; r_low = 0; l_low = 0;
        iter = budget; tmo = 1'b1; seen0 = 1'b0;
        prev = SCLK;
        for (int i = 0; i < budget; i++) begin
            if (SCLK !== prev) edges++;
            if (prev === 1'b1 && SCLK === 1'b0) begin
                falls++;
                w = {w[22:0], DIN};
            end
            prev = SCLK;
            if (SYNC === 1'b0) s_low++;
            if (LDAC === 1'b0) l_low++;
            if (rdy === 1'b0) begin
                r_low++;
                seen0 = 1'b1;
            end else if (seen0) begin
                iter = i;
                tmo  = 1'b0;
                break;
            end
            if (i == inj_at) begin
                cs = 1'b1; op = inj_op; addr = 8'h00; data_in = inj_data;
            end else begin
                cs = 1'b0;
            end
            @(negedge clk);
        end
        cs = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        cs       = 1'b0;
        op       = 4'd0;
        addr     = 8'd0;
        data_in  = 16'd0;

        // Reset then idle
        repeat (5) @(negedge clk);
        check("rst_sclk", SCLK, 1);
        check("rst_sync", SYNC, 1);
        check("rst_din",  DIN,  0);
        check("rst_ldac", LDAC, 1);
        check("rst_rdy",  rdy,  0);
        rst_n = 1'b1;
        #1 check("rdy_before_edge", rdy, 0);
        @(negedge clk);
        check("rdy_after_release", rdy, 1);
        check("idle_sclk", SCLK, 1);
        check("idle_sync", SYNC, 1);
        check("idle_ldac", LDAC, 1);
        check("idle_din",  DIN,  0);

        // op = 0 is a no-op
        issue(4'b0000, 8'h01, 16'hFFFF);
        capture(10, -1, 4'd0, 16'd0, word, nfalls, nedges, sync_low, rdy_low, ldac_low, last_iter, timed_out);
        check("nop_rdy_low",  rdy_low,  0);
        check("nop_sync_low", sync_low, 0);
        check("nop_edges",    nedges,   0);

        // Write + update
        issue(4'b0010, 8'h01, 16'hABCD);
        capture(200, -1, 4'd0, 16'd0, word, nfalls, nedges, sync_low, rdy_low, ldac_low, last_iter, timed_out);
        check("wu_timeout",  timed_out, 0);
        check("wu_word",     word,      24'h31ABCD);
        check("wu_falls",    nfalls,    24);
        check("wu_edges",    nedges,    48);
        check("wu_sync_low", sync_low,  98);
        check("wu_rdy_low",  rdy_low,   101);
        check("wu_ldac_low", ldac_low,  0);
        check("wu_end_iter", last_iter, 102);

        // Write input register only, then LDAC pulse
        issue(4'b0100, 8'h0F, 16'h8000);
        capture(200, -1, 4'd0, 16'd0, word, nfalls, nedges, sync_low, rdy_low, ldac_low, last_iter, timed_out);
        check("wi_timeout",  timed_out, 0);
        check("wi_word",     word,      24'h1F8000);
        check("wi_falls",    nfalls,    24);
        check("wi_ldac_low", ldac_low,  0);
        issue(4'b1000, 8'h00, 16'h0000);
        capture(50, -1, 4'd0, 16'd0, word, nfalls, nedges, sync_low, rdy_low, ldac_low, last_iter, timed_out);
        check("lp_timeout",  timed_out, 0);
        check("lp_ldac_low", ldac_low,  2);
        check("lp_edges",    nedges,    0);
        check("lp_sync_low", sync_low,  0);
        check("lp_rdy_low",  rdy_low,   5);
        check("lp_ldac_end", LDAC,      1);

        // Busy drop: a second write mid-frame is ignored
        issue(4'b0010, 8'h08, 16'hCAFE);
        capture(200, 40, 4'b0010, 16'h1234, word, nfalls, nedges, sync_low, rdy_low, ldac_low, last_iter, timed_out);
        check("bd_timeout",  timed_out, 0);
        check("bd_word",     word,      24'h38CAFE);
        check("bd_sync_low", sync_low,  98);
        check("bd_rdy_low",  rdy_low,   101);
        extra_sync = 0;
        for (int i = 0; i < 20; i++) begin
            if (SYNC === 1'b0 || rdy === 1'b0) extra_sync++;
            @(negedge clk);
        end
        check("bd_no_second_frame", extra_sync, 0);

        // Soft abort at bit 10 (11th falling edge)
        issue(4'b0010, 8'h02, 16'h5555);
        capture(200, 43, 4'b0001, 16'h0000, word, nfalls, nedges, sync_low, rdy_low, ldac_low, last_iter, timed_out);
        check("sa_timeout",  timed_out, 0);
        check("sa_falls",    nfalls,    11);
        check("sa_partial",  word,      24'h000192);
        check("sa_end_iter", last_iter, 45);
        check("sa_sync",     SYNC,      1);
        check("sa_sclk",     SCLK,      1);
        check("sa_din",      DIN,       0);
        issue(4'b0010, 8'h04, 16'h0F0F);
        capture(200, -1, 4'd0, 16'd0, word, nfalls, nedges, sync_low, rdy_low, ldac_low, last_iter, timed_out);
        check("sa_new_word",     word,     24'h340F0F);
        check("sa_new_falls",    nfalls,   24);
        check("sa_new_sync_low", sync_low, 98);

        // Asynchronous reset mid-frame, while SCLK is low
        issue(4'b0010, 8'h01, 16'h1234);
        for (int i = 0; i < 47; i++) @(negedge clk);
        check("ar_pre_sclk", SCLK, 0);
        check("ar_pre_sync", SYNC, 0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_sclk", SCLK, 1);
        check("ar_sync", SYNC, 1);
        check("ar_ldac", LDAC, 1);
        check("ar_din",  DIN,  0);
        check("ar_rdy",  rdy,  0);
        repeat (3) @(negedge clk);
        check("ar_hold_sync", SYNC, 1);
        rst_n = 1'b1;
        #1 check("ar_rdy_release", rdy, 0);
        @(negedge clk);
        check("ar_rdy_after", rdy,  1);
        check("ar_sync_after", SYNC, 1);
        issue(4'b0010, 8'h00, 16'hFFFF);
        capture(200, -1, 4'd0, 16'd0, word, nfalls, nedges, sync_low, rdy_low, ldac_low, last_iter, timed_out);
        check("ar_new_word",    word,    24'h30FFFF);
        check("ar_new_rdy_low", rdy_low, 101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
